dsp_file_server: RTL and testbench
==================================

DSP_FILE_SERVER -- requirements
Module: dsp_file_server

Interface
REQ-001 SHALL have parameter NUM_FILES, default 4, meaning number of independent files.
REQ-002 SHALL have parameter DEPTH, default 16 (power of 2), meaning 32-bit words per file.
REQ-003 SHALL have ports as follows; one clock; reset is asynchronous and active-low.
- wb_clk  in  1  sole clock, rising edge
- wb_rst  in  1  asynchronous active-low reset
- file_num  in  8  file selected by client
- file_read  in  1  read request level
- file_write  in  1  write request level
- file_write_data  in  32  write word
- file_clear  in  1  synchronous pulse: empty all files, clear error
- file_active  out  1  handshake acknowledge
- file_read_data  out  32  read word
- rd_ptr  out  32  read counter of the file selected by file_num
- wr_ptr  out  32  write counter of the file selected by file_num
- file_empty  out  1  selected file holds 0 words
- file_full  out  1  selected file holds DEPTH words
- error  out  1  sticky fault flag

Function
REQ-004 SHALL keep per file a 32-bit rd counter, a 32-bit wr counter and DEPTH words of storage; address = counter mod DEPTH; occupancy = wr - rd, modulo 2^32.
REQ-005 SHALL drive rd_ptr, wr_ptr, file_empty and file_full combinationally from the file selected by file_num; for file_num >= NUM_FILES: all zero, except file_empty = 1.
REQ-006 SHALL implement FSM IDLE -> ACCESS -> HOLD -> RELEASE -> IDLE.
REQ-007 IDLE: on an edge with file_read or file_write high and file_clear low, SHALL latch file_num, perform the operation (REQ-008/009), set file_active = 1, and go to ACCESS.
REQ-008 Read accept: file_read_data <= word at rd address; rd counter += 1.
REQ-009 Write accept: word at wr address <= file_write_data; wr counter += 1.
REQ-010 ACCESS SHALL hold file_active = 1 and go to HOLD; HOLD SHALL hold file_active = 1 and go to RELEASE. file_active is therefore high for exactly 2 cycles per request.
REQ-011 RELEASE SHALL drive file_active = 0 and return to IDLE only on a cycle with file_read and file_write both low. Each request level thus produces exactly one access.
REQ-012 file_read_data SHALL stay stable from acceptance until the next read acceptance.
REQ-013 Read of an empty file SHALL complete the handshake, set file_read_data = 0, leave counters unchanged, and set error.
REQ-014 Write to a full file SHALL complete the handshake, leave storage and counters unchanged, and set error.
REQ-015 A request with file_num >= NUM_FILES, or with file_read and file_write both high, SHALL complete the handshake with no state change and set error.
REQ-016 error SHALL be sticky; only file_clear or reset clears it.
REQ-017 file_clear SHALL zero all counters and error on the next edge, in any state. An in-flight handshake completes normally. In IDLE, a simultaneous request is not accepted that cycle; it is accepted next cycle if still high.
REQ-018 Counter wrap from 0xFFFFFFFF to 0 SHALL be seamless; occupancy arithmetic stays correct.
REQ-019 Storage contents need not be reset.

Reset
REQ-020 wb_rst low SHALL asynchronously force: state IDLE, file_active 0, file_read_data 0, error 0, all counters 0.
REQ-021 Reset asserted mid-handshake SHALL abort the handshake; after release, a still-high request is accepted as new.

Verification
REQ-022 Write 0xA5A5_0001 to file 1, then read file 1 -> file_active high 2 cycles each; read returns 0xA5A5_0001; rd_ptr = wr_ptr = 1; error 0.
REQ-023 Write 16 words to file 0, then a 17th -> file_full = 1 after the 16th; the 17th is dropped; error = 1; wr_ptr = 16.
REQ-024 Read empty file 2 -> handshake completes; file_read_data = 0; rd_ptr = 0; error = 1; file_clear -> error = 0.
REQ-025 Hold file_read high 10 cycles -> exactly one access; rd_ptr += 1; file_active pattern 1,1,0,0...
REQ-026 file_num = 9; or file_read and file_write both high -> handshake completes; no counter changes; error = 1.
REQ-027 wb_rst low during HOLD -> file_active 0 immediately without a clock edge; counters 0 after release.

Source files
------------

// File: rtl/dsp_file_server.sv
// rtl/dsp_file_server.sv - multi-file word FIFO server with a level-request handshake
module dsp_file_server #(
  parameter int NUM_FILES = 4,
  parameter int DEPTH     = 16
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [7:0]  file_num,
  input  logic        file_read,
  input  logic        file_write,
  input  logic [31:0] file_write_data,
  input  logic        file_clear,
  output logic        file_active,
  output logic [31:0] file_read_data,
  output logic [31:0] rd_ptr,
  output logic [31:0] wr_ptr,
  output logic        file_empty,
  output logic        file_full,
  output logic        error
);

  localparam int IDX_W = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD, RELEASE} state_t;

  state_t      state, state_next;
  logic [31:0] rd_cnt [NUM_FILES];
  logic [31:0] wr_cnt [NUM_FILES];
  logic [31:0] mem [NUM_FILES][DEPTH];

  logic             sel_valid;
  logic [IDX_W-1:0] idx;
  logic [31:0]      occupancy;
  logic             accept;
  logic             bad_req;

  // Selected-file status is purely combinational from file_num; out-of-range files look empty.
  always_comb begin
    sel_valid = ({24'd0, file_num} < 32'(NUM_FILES));
    idx       = file_num[IDX_W-1:0];
    rd_ptr    = sel_valid ? rd_cnt[idx] : 32'd0;
    wr_ptr    = sel_valid ? wr_cnt[idx] : 32'd0;
    occupancy = wr_ptr - rd_ptr;
    file_empty = (occupancy == 32'd0);
    file_full  = (occupancy == 32'(DEPTH));
    accept  = (state == IDLE) && (file_read || file_write) && !file_clear;
    bad_req = !sel_valid || (file_read && file_write);
  end

  // Handshake state register.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state and acknowledge: active spans exactly ACCESS and HOLD; RELEASE waits for request drop.
  always_comb begin
    state_next  = state;
    file_active = 1'b0;
    case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  begin file_active = 1'b1; state_next = HOLD; end
      HOLD:    begin file_active = 1'b1; state_next = RELEASE; end
      RELEASE: if (!file_read && !file_write) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counters, read data and sticky error; clear takes priority and blocks acceptance.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      for (int i = 0; i < NUM_FILES; i++) begin
        rd_cnt[i] <= 32'd0;
        wr_cnt[i] <= 32'd0;
      end
      file_read_data <= 32'd0;
      error          <= 1'b0;
    end else if (file_clear) begin
      for (int i = 0; i < NUM_FILES; i++) begin
        rd_cnt[i] <= 32'd0;
        wr_cnt[i] <= 32'd0;
      end
      error <= 1'b0;
    end else if (accept) begin
      if (bad_req) begin
        error <= 1'b1;
      end else if (file_read) begin
        if (file_empty) begin
          file_read_data <= 32'd0;
          error          <= 1'b1;
        end else begin
          file_read_data <= mem[idx][rd_ptr[AW-1:0]];
          rd_cnt[idx]    <= rd_ptr + 32'd1;
        end
      end else if (file_full) begin
        error <= 1'b1;
      end else begin
        wr_cnt[idx] <= wr_ptr + 32'd1;
      end
    end
  end

  // Storage write port; contents are intentionally not reset.
  always_ff @(posedge wb_clk) begin
    if (accept && !bad_req && file_write && !file_full)
      mem[idx][wr_ptr[AW-1:0]] <= file_write_data;
  end

endmodule

// File: tb/tb_dsp_file_server.sv
// tb/tb_dsp_file_server.sv - directed self-checking bench for dsp_file_server
module tb_dsp_file_server;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [7:0]  file_num;
  logic        file_read;
  logic        file_write;
  logic [31:0] file_write_data;
  logic        file_clear;
  logic        file_active;
  logic [31:0] file_read_data;
  logic [31:0] rd_ptr;
  logic [31:0] wr_ptr;
  logic        file_empty;
  logic        file_full;
  logic        error;

  int tests = 0;
  int fails = 0;

  dsp_file_server #(.NUM_FILES(4), .DEPTH(16)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .file_num(file_num), .file_read(file_read),
    .file_write(file_write), .file_write_data(file_write_data), .file_clear(file_clear),
    .file_active(file_active), .file_read_data(file_read_data), .rd_ptr(rd_ptr),
    .wr_ptr(wr_ptr), .file_empty(file_empty), .file_full(file_full), .error(error)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  // One complete handshake with acknowledge pattern 1,1,0 checked, then the request dropped.
  task automatic req(input string tag, input logic rd, input logic wr,
                     input logic [7:0] num, input logic [31:0] data);
    file_num = num; file_read = rd; file_write = wr; file_write_data = data;
    step(); check({tag, "_act1"}, 32'(file_active), 32'd1);
    step(); check({tag, "_act2"}, 32'(file_active), 32'd1);
    step(); check({tag, "_act3"}, 32'(file_active), 32'd0);
    file_read = 1'b0; file_write = 1'b0;
    step();
  endtask

  task automatic clear_pulse();
    file_clear = 1'b1;
    step();
    file_clear = 1'b0;
  endtask

  initial begin
    wb_rst = 1'b0; file_num = 8'd0; file_read = 1'b0; file_write = 1'b0;
    file_write_data = 32'd0; file_clear = 1'b0;
    #3;
    check("rst_active", 32'(file_active), 32'd0);
    check("rst_rdata", file_read_data, 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_rdptr", rd_ptr, 32'd0);
    check("rst_wrptr", wr_ptr, 32'd0);
    check("rst_empty", 32'(file_empty), 32'd1);
    step(); step();
    wb_rst = 1'b1;
    step();

    // Basic write then read on file 1
    req("w1", 1'b0, 1'b1, 8'd1, 32'hA5A5_0001);
    check("w1_wrptr", wr_ptr, 32'd1);
    check("w1_empty", 32'(file_empty), 32'd0);
    req("r1", 1'b1, 1'b0, 8'd1, 32'd0);
    check("r1_data", file_read_data, 32'hA5A5_0001);
    check("r1_rdptr", rd_ptr, 32'd1);
    check("r1_wrptr", wr_ptr, 32'd1);
    check("r1_error", 32'(error), 32'd0);

    // Fill file 0, then overflow
    for (int i = 0; i < 16; i++) req("fill", 1'b0, 1'b1, 8'd0, 32'h100 + 32'(i));
    check("fill_full", 32'(file_full), 32'd1);
    check("fill_wrptr", wr_ptr, 32'd16);
    check("fill_error", 32'(error), 32'd0);
    req("ovf", 1'b0, 1'b1, 8'd0, 32'hDEAD_BEEF);
    check("ovf_wrptr", wr_ptr, 32'd16);
    check("ovf_error", 32'(error), 32'd1);
    req("ovf_rd", 1'b1, 1'b0, 8'd0, 32'd0);
    check("ovf_rd_data", file_read_data, 32'h100);
    check("ovf_rd_rdptr", rd_ptr, 32'd1);
    check("ovf_rd_full", 32'(file_full), 32'd0);
    clear_pulse();
    check("clr_error", 32'(error), 32'd0);
    check("clr_wrptr0", wr_ptr, 32'd0);
    check("clr_rdptr0", rd_ptr, 32'd0);
    file_num = 8'd1;
    #1;
    check("clr_wrptr1", wr_ptr, 32'd0);

    // Read of empty file 2
    req("emp", 1'b1, 1'b0, 8'd2, 32'd0);
    check("emp_data", file_read_data, 32'd0);
    check("emp_rdptr", rd_ptr, 32'd0);
    check("emp_error", 32'(error), 32'd1);
    clear_pulse();
    check("emp_clr_error", 32'(error), 32'd0);

    // Long read level on file 3 produces a single access
    req("w3", 1'b0, 1'b1, 8'd3, 32'h0000_3333);
    file_num = 8'd3; file_read = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("lvl_act", 32'(file_active), (c < 2) ? 32'd1 : 32'd0);
    end
    check("lvl_rdptr", rd_ptr, 32'd1);
    check("lvl_data", file_read_data, 32'h0000_3333);
    file_read = 1'b0;
    step();
    check("lvl_stable", file_read_data, 32'h0000_3333);

    // Invalid file number and conflicting request
    req("bad", 1'b0, 1'b1, 8'd9, 32'h1234_5678);
    check("bad_error", 32'(error), 32'd1);
    check("bad_empty", 32'(file_empty), 32'd1);
    check("bad_wrptr", wr_ptr, 32'd0);
    clear_pulse();
    req("w3b", 1'b0, 1'b1, 8'd3, 32'h0000_4444);
    check("w3b_error", 32'(error), 32'd0);
    req("both", 1'b1, 1'b1, 8'd3, 32'h5555_5555);
    check("both_wrptr", wr_ptr, 32'd1);
    check("both_rdptr", rd_ptr, 32'd0);
    check("both_error", 32'(error), 32'd1);
    check("both_data", file_read_data, 32'h0000_3333);

    // Clear with simultaneous request in IDLE defers acceptance by one cycle
    file_num = 8'd2; file_write = 1'b1; file_write_data = 32'h2222_0000; file_clear = 1'b1;
    step();
    check("cq_act0", 32'(file_active), 32'd0);
    check("cq_wrptr0", wr_ptr, 32'd0);
    check("cq_error", 32'(error), 32'd0);
    file_clear = 1'b0;
    step();
    check("cq_act1", 32'(file_active), 32'd1);
    check("cq_wrptr1", wr_ptr, 32'd1);
    step(); step();
    file_write = 1'b0;
    step();

    // Reset during HOLD aborts asynchronously; still-high request is accepted anew
    file_num = 8'd2; file_write = 1'b1; file_write_data = 32'h2222_0001;
    step(); step();
    check("ar_hold_act", 32'(file_active), 32'd1);
    check("ar_hold_wrptr", wr_ptr, 32'd2);
    #2 wb_rst = 1'b0;
    #1;
    check("ar_act", 32'(file_active), 32'd0);
    check("ar_wrptr", wr_ptr, 32'd0);
    step();
    wb_rst = 1'b1;
    step();
    check("ar_new_act", 32'(file_active), 32'd1);
    check("ar_new_wrptr", wr_ptr, 32'd1);
    step(); step();
    file_write = 1'b0;
    step();
    req("ar_rd", 1'b1, 1'b0, 8'd2, 32'd0);
    check("ar_rd_data", file_read_data, 32'h2222_0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
